// File: rtl/fc_x_feeder_pkg.sv
// Shared constants and FSM encoding for the FC-layer X-vector feeder.
package fc_x_feeder_pkg;
    localparam int DDR_AXIS_DATA_WIDTH = 512;
    localparam int X_DEPTH_DEFAULT     = 4096;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2,
        ST_DONE = 2'd3
    } state_t;
endpackage

// File: rtl/fc_x_feeder_buf.sv
// Simple dual-port vector buffer: one write port for stream beats, one registered read port.
module fc_x_buf
    import fc_x_feeder_pkg::*;
#(
    parameter int WIDTH = DDR_AXIS_DATA_WIDTH,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/fc_x_feeder.sv
// FC-layer X-vector producer: loads one vector from the DDR stream, then replays it n_rep
// times into the X FIFO as zero-point-corrected signed elements with begin/end/last tags.
module fc_x_feeder
    import fc_x_feeder_pkg::*;
#(
    parameter int IN_WIDTH = DDR_AXIS_DATA_WIDTH,
    parameter int X_DEPTH  = X_DEPTH_DEFAULT,
    parameter int ADDR_W   = $clog2(X_DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W:0]     vec_len,
    input  logic [15:0]         n_rep,
    input  logic [7:0]          x_zp,
    output logic                busy,
    output logic                done,
    input  logic [IN_WIDTH-1:0] s_axis_tdata,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    input  logic                x_fifo_almost_full,
    output logic                x_fifo_wr_en,
    output logic signed [8:0]   x_fifo_din,
    output logic                x_fifo_din_vec_begin,
    output logic                x_fifo_din_vec_end,
    output logic                x_fifo_din_last
);
    localparam int BPB   = IN_WIDTH / 8;
    localparam int SEL_W = $clog2(BPB);
    localparam int WORDS = X_DEPTH / BPB;
    localparam int WA_W  = ADDR_W - SEL_W;

    function automatic logic signed [8:0] sub_zp(input logic [7:0] b, input logic [7:0] z);
        return $signed({1'b0, b}) - $signed({1'b0, z});
    endfunction

    state_t            state;
    logic [ADDR_W-1:0] len_m1;
    logic [ADDR_W-1:0] elem;
    logic [15:0]       nrep_m1;
    logic [15:0]       rep;
    logic [7:0]        zp;
    logic [WA_W-1:0]   beat_cnt;
    logic              issue_done;

    logic              beat_fire;
    logic              vld_p0, begin_p0, end_p0, last_p0;
    logic              vld_p1, begin_p1, end_p1, last_p1;
    logic [SEL_W-1:0]  sel_p1;
    logic [IN_WIDTH-1:0] rd_data_p1;
    logic [7:0]        byte_p1;

    assign beat_fire = s_axis_tvalid & s_axis_tready;
    // Issue stalls on almost_full; at most two elements are already in flight.
    assign vld_p0   = (state == ST_PLAY) && !issue_done && !x_fifo_almost_full;
    assign begin_p0 = (elem == '0);
    assign end_p0   = (elem == len_m1);
    assign last_p0  = end_p0 && (rep == nrep_m1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            s_axis_tready <= 1'b0;
            len_m1        <= '0;
            nrep_m1       <= '0;
            zp            <= '0;
            beat_cnt      <= '0;
            elem          <= '0;
            rep           <= '0;
            issue_done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy       <= 1'b1;
                        len_m1     <= ADDR_W'(vec_len - (ADDR_W+1)'(1));
                        nrep_m1    <= n_rep - 16'd1;
                        zp         <= x_zp;
                        beat_cnt   <= '0;
                        elem       <= '0;
                        rep        <= '0;
                        issue_done <= 1'b0;
                        if (vec_len == '0 || n_rep == 16'd0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state         <= ST_LOAD;
                            s_axis_tready <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    // Final beat index is (vec_len-1)/BPB; trailing bytes in it are never read.
                    if (beat_fire) begin
                        if (beat_cnt == len_m1[ADDR_W-1:SEL_W]) begin
                            s_axis_tready <= 1'b0;
                            state         <= ST_PLAY;
                        end else begin
                            beat_cnt <= beat_cnt + WA_W'(1);
                        end
                    end
                end
                ST_PLAY: begin
                    if (vld_p0) begin
                        if (last_p0) begin
                            issue_done <= 1'b1;
                        end else if (end_p0) begin
                            elem <= '0;
                            rep  <= rep + 16'd1;
                        end else begin
                            elem <= elem + ADDR_W'(1);
                        end
                    end
                    if (issue_done && !vld_p1) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    fc_x_buf #(
        .WIDTH (IN_WIDTH),
        .DEPTH (WORDS),
        .AW    (WA_W)
    ) u_buf (
        .clk     (clk),
        .wr_en   (beat_fire),
        .wr_addr (beat_cnt),
        .wr_data (s_axis_tdata),
        .rd_addr (elem[ADDR_W-1:SEL_W]),
        .rd_data (rd_data_p1)
    );

    // Stage p1: buffer word in flight, byte lane and flags carried alongside
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            begin_p1 <= 1'b0;
            end_p1   <= 1'b0;
            last_p1  <= 1'b0;
        end else begin
            vld_p1   <= vld_p0;
            begin_p1 <= begin_p0;
            end_p1   <= end_p0;
            last_p1  <= last_p0;
        end
    end

    always_ff @(posedge clk) begin
        sel_p1 <= elem[SEL_W-1:0];
    end

    assign byte_p1 = rd_data_p1[{sel_p1, 3'b000} +: 8];

    // Stage p2: byte select and zero-point subtract; outputs held at zero between writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_fifo_wr_en         <= 1'b0;
            x_fifo_din           <= '0;
            x_fifo_din_vec_begin <= 1'b0;
            x_fifo_din_vec_end   <= 1'b0;
            x_fifo_din_last      <= 1'b0;
        end else begin
            x_fifo_wr_en         <= vld_p1;
            x_fifo_din           <= vld_p1 ? sub_zp(byte_p1, zp) : '0;
            x_fifo_din_vec_begin <= vld_p1 & begin_p1;
            x_fifo_din_vec_end   <= vld_p1 & end_p1;
            x_fifo_din_last      <= vld_p1 & last_p1;
        end
    end
endmodule

// File: tb/tb_fc_x_feeder.sv
// Scoreboard bench for fc_x_feeder: expected writes queued at job start, compared as the FIFO side writes.
module tb_fc_x_feeder;
    logic               clk;
    logic               rst;
    logic               start;
    logic [12:0]        vec_len;
    logic [15:0]        n_rep;
    logic [7:0]         x_zp;
    logic               busy;
    logic               done;
    logic [511:0]       tdata;
    logic               tvalid;
    logic               tready;
    logic               af;
    logic               wr_en;
    logic signed [8:0]  din;
    logic               vb, ve, vl;

    logic [7:0]  xb [4096];
    logic [11:0] sb [$];
    int n_vec = 0;
    int n_err = 0;
    int nwr, nbeg, nend, nlast, ndone, first_wr, last_wr;

    fc_x_feeder dut (
        .clk                  (clk),
        .rst                  (rst),
        .start                (start),
        .vec_len              (vec_len),
        .n_rep                (n_rep),
        .x_zp                 (x_zp),
        .busy                 (busy),
        .done                 (done),
        .s_axis_tdata         (tdata),
        .s_axis_tvalid        (tvalid),
        .s_axis_tready        (tready),
        .x_fifo_almost_full   (af),
        .x_fifo_wr_en         (wr_en),
        .x_fifo_din           (din),
        .x_fifo_din_vec_begin (vb),
        .x_fifo_din_vec_end   (ve),
        .x_fifo_din_last      (vl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic build(input int len, input int nrep, input logic [7:0] zp, input int pat);
        logic signed [8:0] d;
        for (int i = 0; i < 4096; i++)
            xb[i] = (pat == 0) ? 8'(i) : (pat == 1) ? 8'($urandom) : 8'hFF;
        for (int r = 0; r < nrep; r++)
            for (int e = 0; e < len; e++) begin
                d = $signed({1'b0, xb[e]}) - $signed({1'b0, zp});
                sb.push_back({d, e == 0, e == len - 1, (e == len - 1) && (r == nrep - 1)});
            end
    endtask

    task automatic start_job(input int len, input int nrep, input logic [7:0] zp);
        @(posedge clk); #1;
        vec_len = 13'(len);
        n_rep   = 16'(nrep);
        x_zp    = zp;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic load_vec(input int len, input bit gap);
        int nb;
        bit acc;
        nb = (len + 63) / 64;
        for (int k = 0; k < nb; k++) begin
            if (gap && $urandom_range(0, 1) == 1) begin
                tvalid = 1'b0;
                @(posedge clk); #1;
            end
            for (int j = 0; j < 64; j++)
                tdata[j*8 +: 8] = (k*64 + j < len) ? xb[k*64 + j] : 8'($urandom);
            tvalid = 1'b1;
            acc = 1'b0;
            for (int t = 0; t < 50 && !acc; t++) begin
                @(negedge clk);
                acc = tready;
                @(posedge clk); #1;
            end
            if (!acc) begin
                n_vec++; n_err++;
                $display("FAIL load_beat%0d tready=0 required 1 within 50 cycles", k);
                tvalid = 1'b0;
                return;
            end
        end
        tvalid = 1'b0;
        n_vec++;
        if (tready !== 1'b0) begin
            n_err++;
            $display("FAIL load_end tready=%b required 0 after %0d beats", tready, nb);
        end
    endtask

    // Runs cycles, scoreboarding every write, until a few cycles past done (or max_cyc).
    task automatic play(input int max_cyc, input bit af_rand, input int start_at, input bit expect_done);
        int post, af_run;
        logic [11:0] got, exp;
        post = 0; af_run = 0;
        nwr = 0; nbeg = 0; nend = 0; nlast = 0; ndone = 0; first_wr = -1; last_wr = -1;
        for (int cyc = 0; cyc < max_cyc; cyc++) begin
            @(posedge clk); #1;
            af    = af_rand ? 1'($urandom_range(0, 1)) : 1'b0;
            start = (cyc == start_at);
            @(negedge clk);
            af_run = af ? af_run + 1 : 0;
            got = {din, vb, ve, vl};
            if (wr_en) begin
                nwr++;
                if (first_wr < 0) first_wr = cyc;
                last_wr = cyc;
                nbeg += int'(vb); nend += int'(ve); nlast += int'(vl);
                n_vec++;
                if (af_run >= 3) begin
                    n_err++;
                    $display("FAIL af_overrun write with almost_full high for %0d cycles, required <3", af_run);
                end
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL extra_write din=%0d bel=%b required no write", $signed(got[11:3]), got[2:0]);
                end else begin
                    exp = sb.pop_front();
                    if (got !== exp) begin
                        n_err++;
                        $display("FAIL write%0d din=%0d bel=%b required din=%0d bel=%b",
                                 nwr - 1, $signed(got[11:3]), got[2:0], $signed(exp[11:3]), exp[2:0]);
                    end
                end
            end else begin
                n_vec++;
                if (got !== 12'd0) begin
                    n_err++;
                    $display("FAIL idle_outputs din/flags=%h required 0 while wr_en=0", got);
                end
            end
            if (post > 0) post++;
            if (done) begin
                ndone++;
                if (post == 0) post = 1;
            end
            if (post == 2) begin
                n_vec++;
                if (busy !== 1'b0) begin
                    n_err++;
                    $display("FAIL busy_after_done busy=%b required 0", busy);
                end
            end
            if (post >= 4) break;
        end
        start = 1'b0;
        af    = 1'b0;
        if (expect_done) begin
            n_vec++;
            if (ndone != 1) begin
                n_err++;
                $display("FAIL done_count done pulses=%0d required 1", ndone);
            end
        end
    endtask

    task automatic run_job(input int len, input int nrep, input logic [7:0] zp, input int pat,
                           input bit af_rand, input bit gap, input int start_at);
        build(len, nrep, zp, pat);
        start_job(len, nrep, zp);
        load_vec(len, gap);
        play(4000, af_rand, start_at, 1'b1);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_drained %0d writes missing, required 0", sb.size());
        end
        sb.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; vec_len = '0; n_rep = '0; x_zp = '0;
        tdata = '0; tvalid = 1'b0; af = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({busy, done, tready} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_ctrl busy/done/tready=%b required 000", {busy, done, tready});
        end
        n_vec++;
        if ({wr_en, din, vb, ve, vl} !== 13'd0) begin
            n_err++;
            $display("FAIL reset_fifo wr_en/din/flags=%h required 0", {wr_en, din, vb, ve, vl});
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        run_job(128, 1, 8'd0, 0, 1'b0, 1'b0, -1);
        n_vec++;
        if ({nwr, nbeg, nend, nlast} !== {32'd128, 32'd1, 32'd1, 32'd1}) begin
            n_err++;
            $display("FAIL basic_counts wr=%0d beg=%0d end=%0d last=%0d required 128/1/1/1", nwr, nbeg, nend, nlast);
        end
        n_vec++;
        if (last_wr - first_wr + 1 != nwr) begin
            n_err++;
            $display("FAIL basic_b2b write span=%0d cycles required %0d", last_wr - first_wr + 1, nwr);
        end
    endtask

    task automatic test_replay_zp();
        run_job(100, 3, 8'd128, 0, 1'b0, 1'b1, -1);
        n_vec++;
        if ({nwr, nbeg, nend, nlast} !== {32'd300, 32'd3, 32'd3, 32'd1}) begin
            n_err++;
            $display("FAIL replay_counts wr=%0d beg=%0d end=%0d last=%0d required 300/3/3/1", nwr, nbeg, nend, nlast);
        end
    endtask

    task automatic test_almost_full();
        run_job(200, 2, 8'($urandom), 1, 1'b1, 1'b1, -1);
        n_vec++;
        if (nwr != 400) begin
            n_err++;
            $display("FAIL af_count wr=%0d required 400", nwr);
        end
    endtask

    task automatic test_single_elem();
        run_job(1, 2, 8'd0, 2, 1'b0, 1'b0, -1);
        n_vec++;
        if ({nwr, nbeg, nend, nlast} !== {32'd2, 32'd2, 32'd2, 32'd1}) begin
            n_err++;
            $display("FAIL single_counts wr=%0d beg=%0d end=%0d last=%0d required 2/2/2/1", nwr, nbeg, nend, nlast);
        end
    endtask

    task automatic test_zero_len();
        int bad;
        for (int k = 0; k < 2; k++) begin
            start_job(k == 0 ? 0 : 10, k == 0 ? 5 : 0, 8'd7);
            n_vec++;
            if ({done, busy, tready} !== 3'b110) begin
                n_err++;
                $display("FAIL zero%0d_done done/busy/tready=%b required 110", k, {done, busy, tready});
            end
            // Start offered during the DONE cycle must be dropped.
            vec_len = 13'd10; n_rep = 16'd1; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            n_vec++;
            if ({done, busy, tready} !== 3'b000) begin
                n_err++;
                $display("FAIL zero%0d_idle done/busy/tready=%b required 000", k, {done, busy, tready});
            end
            bad = 0;
            repeat (4) begin
                @(negedge clk);
                if (busy || tready || wr_en || done) bad++;
            end
            n_vec++;
            if (bad != 0) begin
                n_err++;
                $display("FAIL zero%0d_quiet activity in %0d cycles required 0", k, bad);
            end
        end
    endtask

    task automatic test_back_to_back();
        run_job(64, 2, 8'd3, 1, 1'b0, 1'b0, 20);
        n_vec++;
        if (nwr != 128) begin
            n_err++;
            $display("FAIL busy_start wr=%0d required 128", nwr);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        build(128, 4, 8'd0, 0);
        start_job(128, 4, 8'd0);
        load_vec(128, 1'b0);
        play(30, 1'b0, -1, 1'b0);
        @(posedge clk); #2;
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({wr_en, busy, tready, done} !== 4'b0000) begin
            n_err++;
            $display("FAIL midrst wr_en/busy/tready/done=%b required 0000", {wr_en, busy, tready, done});
        end
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (wr_en || vb || ve || vl || busy) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL midrst_quiet activity in %0d cycles required 0", bad);
        end
        test_basic();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_replay_zp();
        test_almost_full();
        test_single_elem();
        test_zero_len();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
